fifo_sync_flags: RTL and testbench

//   Single-clock FIFO, next generation of the team's FIFO family for same-clock paths.
//   Non-power-of-2 depth, occupancy count, programmable almost-full/almost-empty flags,

---
 rtl/fifo_sync_flags.sv | 113 +++++++++++
 tb/tb_fifo_sync_flags.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_flags.sv
// rtl/fifo_sync_flags.sv - single-clock FIFO, any depth, occupancy count, almost flags, optional FWFT read
// Optional sticky overflow/underflow ports: define FIFO_SYNC_ERR_EN.
module fifo_sync_flags #(
    parameter int DW        = 8,
    parameter int DEPTH     = 16,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = 0,
    localparam int AW       = $clog2(DEPTH),
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          w_en,
    input  logic [DW-1:0] w_data,
    output logic          full,
    output logic          afull,
    input  logic          r_en,
    output logic [DW-1:0] r_data,
    output logic          empty,
    output logic          aempty,
    output logic [CW-1:0] count
`ifdef FIFO_SYNC_ERR_EN
    ,
    output logic          ovf,
    output logic          udf
`endif
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] w_ptr;
    logic [AW-1:0] r_ptr;
    logic          w_acc;
    logic          r_acc;
    logic [CW-1:0] count_next;

    assign w_acc = w_en & ~full;
    assign r_acc = r_en & ~empty;

    always_comb begin
        count_next = count;
        if (w_acc && !r_acc) begin
            count_next = count + CW'(1);
        end else if (r_acc && !w_acc) begin
            count_next = count - CW'(1);
        end
    end

    // Pointers wrap at DEPTH-1 explicitly so non-power-of-2 depths use every entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_ptr  <= '0;
            r_ptr  <= '0;
            count  <= '0;
            full   <= 1'b0;
            afull  <= 1'b0;
            empty  <= 1'b1;
            aempty <= 1'b1;
        end else begin
            if (w_acc) begin
                w_ptr <= (w_ptr == AW'(DEPTH - 1)) ? '0 : w_ptr + AW'(1);
            end
            if (r_acc) begin
                r_ptr <= (r_ptr == AW'(DEPTH - 1)) ? '0 : r_ptr + AW'(1);
            end
            count  <= count_next;
            full   <= (count_next == CW'(DEPTH));
            afull  <= (count_next >= CW'(AFULL_TH));
            empty  <= (count_next == '0);
            aempty <= (count_next <= CW'(AEMPTY_TH));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_acc) begin
            mem[w_ptr] <= w_data;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word shown directly; zero while nothing valid so stale storage never leaks.
            assign r_data = empty ? '0 : mem[r_ptr];
        end else begin : g_std
            logic [DW-1:0] r_data_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_data_q <= '0;
                end else if (r_acc) begin
                    r_data_q <= mem[r_ptr];
                end
            end
            assign r_data = r_data_q;
        end
    endgenerate

`ifdef FIFO_SYNC_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (w_en && full) begin
                ovf <= 1'b1;
            end
            if (r_en && empty) begin
                udf <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_sync_flags.sv
// tb/tb_fifo_sync_flags.sv - self-checking bench: standard-mode DEPTH=6 and FWFT DEPTH=16 instances vs queue model
module tb_fifo_sync_flags;

    localparam int DA = 6;
    localparam int DB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       a_w_en = 1'b0, a_r_en = 1'b0;
    logic [7:0] a_w_data = 8'h00;
    logic       a_full, a_afull, a_empty, a_aempty;
    logic [7:0] a_r_data;
    logic [2:0] a_count;

    logic       b_w_en = 1'b0, b_r_en = 1'b0;
    logic [7:0] b_w_data = 8'h00;
    logic       b_full, b_afull, b_empty, b_aempty;
    logic [7:0] b_r_data;
    logic [4:0] b_count;

`ifdef FIFO_SYNC_ERR_EN
    logic a_ovf, a_udf, b_ovf, b_udf;
`endif

    always #5 clk = ~clk;

    fifo_sync_flags #(.DW(8), .DEPTH(DA), .AFULL_TH(5), .AEMPTY_TH(1), .FWFT(0)) u_a (
        .clk(clk), .rst(rst), .w_en(a_w_en), .w_data(a_w_data), .full(a_full), .afull(a_afull),
        .r_en(a_r_en), .r_data(a_r_data), .empty(a_empty), .aempty(a_aempty), .count(a_count)
`ifdef FIFO_SYNC_ERR_EN
        , .ovf(a_ovf), .udf(a_udf)
`endif
    );

    fifo_sync_flags #(.DW(8), .DEPTH(DB), .AFULL_TH(14), .AEMPTY_TH(2), .FWFT(1)) u_b (
        .clk(clk), .rst(rst), .w_en(b_w_en), .w_data(b_w_data), .full(b_full), .afull(b_afull),
        .r_en(b_r_en), .r_data(b_r_data), .empty(b_empty), .aempty(b_aempty), .count(b_count)
`ifdef FIFO_SYNC_ERR_EN
        , .ovf(b_ovf), .udf(b_udf)
`endif
    );

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] exp_a_rdata = 8'h00;
    logic       exp_a_ovf = 1'b0, exp_a_udf = 1'b0, exp_b_ovf = 1'b0, exp_b_udf = 1'b0;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("a_count", 32'(a_count), qa.size());
        chk("a_full", a_full, qa.size() == DA);
        chk("a_afull", a_afull, qa.size() >= 5);
        chk("a_empty", a_empty, qa.size() == 0);
        chk("a_aempty", a_aempty, qa.size() <= 1);
        chk("a_r_data", a_r_data, exp_a_rdata);
        chk("b_count", 32'(b_count), qb.size());
        chk("b_full", b_full, qb.size() == DB);
        chk("b_afull", b_afull, qb.size() >= 14);
        chk("b_empty", b_empty, qb.size() == 0);
        chk("b_aempty", b_aempty, qb.size() <= 2);
        chk("b_r_data", b_r_data, (qb.size() > 0) ? qb[0] : 8'h00);
`ifdef FIFO_SYNC_ERR_EN
        chk("a_ovf", a_ovf, exp_a_ovf);
        chk("a_udf", a_udf, exp_a_udf);
        chk("b_ovf", b_ovf, exp_b_ovf);
        chk("b_udf", b_udf, exp_b_udf);
`endif
    endtask

    // Advance one clock; the model applies the FIFO rules to the inputs held across the edge.
    task automatic tick();
        int sa;
        int sb;
        @(posedge clk);
        sa = qa.size();
        sb = qb.size();
        if (rst) begin
            qa.delete();
            qb.delete();
            exp_a_rdata = 8'h00;
            exp_a_ovf = 1'b0; exp_a_udf = 1'b0; exp_b_ovf = 1'b0; exp_b_udf = 1'b0;
        end else begin
            if (a_w_en && sa == DA) exp_a_ovf = 1'b1;
            if (a_r_en && sa == 0)  exp_a_udf = 1'b1;
            if (a_r_en && sa > 0)   exp_a_rdata = qa.pop_front();
            if (a_w_en && sa < DA)  qa.push_back(a_w_data);
            if (b_w_en && sb == DB) exp_b_ovf = 1'b1;
            if (b_r_en && sb == 0)  exp_b_udf = 1'b1;
            if (b_r_en && sb > 0)   void'(qb.pop_front());
            if (b_w_en && sb < DB)  qb.push_back(b_w_data);
        end
        #1;
        compare_all();
    endtask

    task automatic drive(input logic aw, input logic [7:0] ad, input logic ar,
                         input logic bw, input logic [7:0] bd, input logic br);
        a_w_en = aw; a_w_data = ad; a_r_en = ar;
        b_w_en = bw; b_w_data = bd; b_r_en = br;
        tick();
    endtask

    initial begin
        // Reset held two cycles
        drive(1'b1, 8'hEE, 1'b1, 1'b1, 8'hEE, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("rst_empty", a_empty, 1'b1);
        chk("rst_aempty", a_aempty, 1'b1);
        chk("rst_full", a_full, 1'b0);
        chk("rst_count", 32'(a_count), 0);
        chk("rst_r_data", a_r_data, 8'h00);
        chk("rst_b_r_data", b_r_data, 8'h00);
        rst = 1'b0;

        // Fill DEPTH=6, drop 7th write, then read back in order
        for (int i = 1; i <= DA; i++) drive(1'b1, 8'(i), 1'b0, 1'b0, 8'h00, 1'b0);
        chk("fill_full", a_full, 1'b1);
        chk("fill_count", 32'(a_count), 6);
        drive(1'b1, 8'h07, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("drop7_count", 32'(a_count), 6);
        for (int i = 1; i <= DA; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
            chk("rd_seq", a_r_data, 32'(i));
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("drain_empty", a_empty, 1'b1);

        // 20 interleaved words across pointer wrap
        for (int k = 0; k < 22; k++) begin
            drive(k < 20, 8'(8'h10 + k), k >= 2, 1'b0, 8'h00, 1'b0);
            if (k >= 2) chk("wrap_seq", a_r_data, 32'(8'h10 + k - 2));
        end
        chk("wrap_empty", a_empty, 1'b1);

        // FWFT: word into empty FIFO visible next cycle without r_en
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0);
        chk("fwft_empty", b_empty, 1'b0);
        chk("fwft_data", b_r_data, 8'hA5);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h02, 1'b0);
        chk("th_aempty_at2", b_aempty, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 1'b0);
        chk("th_aempty_at3", b_aempty, 1'b0);
        for (int i = 4; i <= 13; i++) drive(1'b0, 8'h00, 1'b0, 1'b1, 8'(i), 1'b0);
        chk("th_afull_at13", b_afull, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h0E, 1'b0);
        chk("th_afull_at14", b_afull, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h0F, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h10, 1'b0);
        chk("b_full16", b_full, 1'b1);
        chk("fwft_head_held", b_r_data, 8'hA5);

        // Simultaneous w_en+r_en when full (read wins) and when empty (write wins)
        for (int i = 0; i < DA; i++) drive(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 8'h99, 1'b1, 1'b1, 8'h99, 1'b1);
        chk("full_both_count", 32'(a_count), 5);
        chk("full_both_data", a_r_data, 8'h40);
        chk("full_both_b_count", 32'(b_count), 15);
        chk("full_both_b_head", b_r_data, 8'h02);
        for (int i = 0; i < 5; i++) drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("empty_both_count", 32'(a_count), 1);
        chk("empty_both_data", a_r_data, 8'h45);
        for (int i = 0; i < 15; i++) drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("b_drained", b_empty, 1'b1);

`ifdef FIFO_SYNC_ERR_EN
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("udf_set", b_udf, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 1'b0);
        chk("udf_held", b_udf, 1'b1);
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        chk("udf_clr", b_udf, 1'b0);
`endif

        // Randomized traffic with alternating fill/drain bias and rare resets
        for (int n = 0; n < 600; n++) begin
            int wp;
            wp = ((n / 60) % 2 == 0) ? 75 : 25;
            rst = ($urandom_range(0, 149) == 0);
            drive($urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < (100 - wp),
                  $urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < (100 - wp));
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
